// File: rtl/fletcher_pkg.sv
// Shared definitions for the Fletcher checksum generator/checker pair:
// legal checksum widths, half-width derivation and the checker state encoding.
package fletcher_pkg;

  localparam int WIDTH_16 = 16;
  localparam int WIDTH_32 = 32;
  localparam int WIDTH_64 = 64;

  function automatic bit isLegalWidth(input int width);
    return (width == WIDTH_16) || (width == WIDTH_32) || (width == WIDTH_64);
  endfunction

  function automatic int halfWidth(input int width);
    return width / 2;
  endfunction

  typedef enum logic [1:0] {
    ST_DATA   = 2'd0,
    ST_CHK_B  = 2'd1,
    ST_CHK_A  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/fletcher_mod_add.sv
// Ones'-complement style add modulo 2^H-1 with end-around carry; the result
// is canonicalised so that the all-ones pattern never appears.
module fletcher_mod_add #(
  parameter int H = 16
) (
  input  logic [H-1:0] i_x,
  input  logic [H-1:0] i_y,
  output logic [H-1:0] o_sum
);

  logic [H:0]   w_raw;
  logic [H-1:0] w_wrapped;

  assign w_raw     = {1'b0, i_x} + {1'b0, i_y};
  assign w_wrapped = w_raw[H] ? (w_raw[H-1:0] + H'(1)) : w_raw[H-1:0];
  assign o_sum     = (w_wrapped == {H{1'b1}}) ? '0 : w_wrapped;

endmodule

// File: rtl/fletcher_checksum_checker.sv
// Receive-side Fletcher checksum verifier: accumulates data words, then
// compares the two trailing checksum words against the recomputed {B, A}.
module fletcher_checksum_checker
  import fletcher_pkg::*;
#(
  parameter int Width      = 32,
  parameter int CountWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [Width/2-1:0]      in_data,
  input  logic                    in_last,
  output logic                    res_valid,
  output logic                    res_ok,
  output logic [Width-1:0]        res_sum,
  output logic [CountWidth-1:0]   res_count
);

  localparam int H = halfWidth(Width);
  localparam logic [CountWidth-1:0] CountMax = '1;

  if (!isLegalWidth(Width)) begin : g_badWidth
    $error("fletcher_checksum_checker: Width must be 16, 32 or 64");
  end

  state_t                  r_state;
  logic [H-1:0]            r_a;
  logic [H-1:0]            r_b;
  logic [H-1:0]            r_rxB;
  logic [CountWidth-1:0]   r_count;
  logic                    r_resValid;
  logic                    r_resOk;
  logic [Width-1:0]        r_resSum;
  logic [CountWidth-1:0]   r_resCount;

  logic                    w_accept;
  logic [H-1:0]            w_aNext;
  logic [H-1:0]            w_bNext;
  logic [H-1:0]            w_rxCanon;

  // B consumes the freshly updated A within the same cycle.
  fletcher_mod_add #(.H(H)) u_addA (.i_x(r_a), .i_y(in_data), .o_sum(w_aNext));
  fletcher_mod_add #(.H(H)) u_addB (.i_x(r_b), .i_y(w_aNext), .o_sum(w_bNext));

  assign w_accept  = in_valid && in_ready;
  assign w_rxCanon = (in_data == {H{1'b1}}) ? '0 : in_data;
  assign in_ready  = (r_state != ST_RESULT);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= ST_DATA;
      r_a        <= '0;
      r_b        <= '0;
      r_rxB      <= '0;
      r_count    <= '0;
      r_resValid <= 1'b0;
      r_resOk    <= 1'b0;
      r_resSum   <= '0;
      r_resCount <= '0;
    end else begin
      case (r_state)
        ST_DATA: begin
          if (w_accept) begin
            r_a <= w_aNext;
            r_b <= w_bNext;
            if (r_count != CountMax) r_count <= r_count + CountWidth'(1);
            if (in_last) r_state <= ST_CHK_B;
          end
        end
        ST_CHK_B: begin
          if (w_accept) begin
            r_rxB   <= w_rxCanon;
            r_state <= ST_CHK_A;
          end
        end
        ST_CHK_A: begin
          if (w_accept) begin
            r_resValid <= 1'b1;
            r_resOk    <= (r_rxB == r_b) && (w_rxCanon == r_a);
            r_resSum   <= {r_b, r_a};
            r_resCount <= r_count;
            r_state    <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          r_resValid <= 1'b0;
          r_a        <= '0;
          r_b        <= '0;
          r_count    <= '0;
          r_state    <= ST_DATA;
        end
        default: r_state <= ST_DATA;
      endcase
    end
  end

  assign res_valid = r_resValid;
  assign res_ok    = r_resOk;
  assign res_sum   = r_resSum;
  assign res_count = r_resCount;

endmodule

// File: tb/tb_fletcher_checksum_checker.sv
// Scoreboard bench for fletcher_checksum_checker: a Width=16 instance with a
// 3-bit counter (to reach saturation) and a Width=32 instance with defaults.
module tb_fletcher_checksum_checker;

  typedef struct {
    bit          ok;
    logic [31:0] sum;
    int          count;
  } exp_t;

  logic        clk;
  logic        rst_;

  logic        v16, rdy16, l16, rv16, ok16;
  logic [7:0]  d16;
  logic [15:0] sum16;
  logic [2:0]  cnt16;

  logic        v32, rdy32, l32, rv32, ok32;
  logic [15:0] d32;
  logic [31:0] sum32;
  logic [15:0] cnt32;

  exp_t        q16[$];
  exp_t        q32[$];
  logic [31:0] frameWords[$];
  int          checks;
  int          failures;

  fletcher_checksum_checker #(.Width(16), .CountWidth(3)) dut16 (
    .clk(clk), .rst_(rst_), .in_valid(v16), .in_ready(rdy16), .in_data(d16),
    .in_last(l16), .res_valid(rv16), .res_ok(ok16), .res_sum(sum16), .res_count(cnt16)
  );

  fletcher_checksum_checker #(.Width(32), .CountWidth(16)) dut32 (
    .clk(clk), .rst_(rst_), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_last(l32), .res_valid(rv32), .res_ok(ok32), .res_sum(sum32), .res_count(cnt32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Fletcher reference from the arithmetic definition: sums modulo 2^H-1.
  function automatic exp_t modelFrame(input int w, input logic [31:0] rxB, input logic [31:0] rxA);
    exp_t   e;
    longint m;
    longint a;
    longint b;
    int     cmax;
    int     h;
    h    = w / 2;
    m    = (longint'(1) << h) - 1;
    cmax = (w == 16) ? 7 : 65535;
    a = 0;
    b = 0;
    foreach (frameWords[i]) begin
      a = (a + longint'(frameWords[i])) % m;
      b = (b + a) % m;
    end
    e.sum   = 32'((b << h) | a);
    e.ok    = ((longint'(rxB) % m) == b) && ((longint'(rxA) % m) == a);
    e.count = (frameWords.size() > cmax) ? cmax : frameWords.size();
    return e;
  endfunction

  task automatic applyStimulus(input int w, input logic [31:0] d, input bit last, input int gapMax);
    int gaps;
    int waitCycles;
    bit rdyNow;
    gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    v16 = 1'b0;
    v32 = 1'b0;
    repeat (gaps) begin
      @(posedge clk); #1;
    end
    if (w == 16) begin
      d16 = d[7:0];  l16 = last; v16 = 1'b1;
    end else begin
      d32 = d[15:0]; l32 = last; v32 = 1'b1;
    end
    waitCycles = 0;
    forever begin
      rdyNow = (w == 16) ? rdy16 : rdy32;
      @(posedge clk); #1;
      if (rdyNow) break;
      waitCycles++;
      if (waitCycles > 50) begin
        checkOutput("ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    v16 = 1'b0; l16 = 1'b0;
    v32 = 1'b0; l32 = 1'b0;
  endtask

  task automatic sendFrame(input int w, input logic [31:0] rxB, input logic [31:0] rxA, input int gapMax);
    exp_t e;
    e = modelFrame(w, rxB, rxA);
    if (w == 16) q16.push_back(e);
    else         q32.push_back(e);
    foreach (frameWords[i]) applyStimulus(w, frameWords[i], (i == frameWords.size() - 1), gapMax);
    applyStimulus(w, rxB, 1'b0, gapMax);
    applyStimulus(w, rxA, 1'b1, gapMax);
    checkOutput("latency_valid", (w == 16) ? rv16 : rv32, 64'd1);
    checkOutput("result_ready_low", (w == 16) ? rdy16 : rdy32, 64'd0);
  endtask

  function automatic logic [31:0] correctSum(input int w);
    exp_t e;
    e = modelFrame(w, 32'd0, 32'd0);
    return e.sum;
  endfunction

  task automatic loadAbcde();
    frameWords = {32'h61, 32'h62, 32'h63, 32'h64, 32'h65};
  endtask

  task automatic loadRandom(input int w, input int len);
    logic [31:0] mask;
    mask = (w == 16) ? 32'hFF : 32'hFFFF;
    frameWords = {};
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(7, 0) == 0) frameWords.push_back(mask);
      else                           frameWords.push_back($urandom() & mask);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ready16", rdy16, 64'd1);
    checkOutput("rst_valid16", rv16, 64'd0);
    checkOutput("rst_ok16", ok16, 64'd0);
    checkOutput("rst_sum16", sum16, 64'd0);
    checkOutput("rst_count16", cnt16, 64'd0);
    checkOutput("rst_ready32", rdy32, 64'd1);
    checkOutput("rst_valid32", rv32, 64'd0);
    checkOutput("rst_sum32", sum32, 64'd0);
    checkOutput("rst_count32", cnt32, 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_ && rv16) begin
      if (q16.size() == 0) checkOutput("unexpected_res16", rv16, 64'd0);
      else begin
        exp_t e;
        e = q16.pop_front();
        checkOutput("res_ok16", ok16, e.ok);
        checkOutput("res_sum16", sum16, e.sum[15:0]);
        checkOutput("res_count16", cnt16, e.count);
        checkOutput("ready_in_result16", rdy16, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ && rv32) begin
      if (q32.size() == 0) checkOutput("unexpected_res32", rv32, 64'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        checkOutput("res_ok32", ok32, e.ok);
        checkOutput("res_sum32", sum32, e.sum);
        checkOutput("res_count32", cnt32, e.count);
        checkOutput("ready_in_result32", rdy32, 64'd0);
      end
    end
  end

  initial begin
    logic [31:0] s;
    checks = 0;
    failures = 0;
    rst_ = 1'b0;
    v16 = 1'b0; l16 = 1'b0; d16 = '0;
    v32 = 1'b0; l32 = 1'b0; d32 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    rst_ = 1'b1;
    @(posedge clk); #1;

    loadAbcde();
    sendFrame(16, 32'hC8, 32'hF0, 0);
    sendFrame(16, 32'hF0, 32'hC8, 0);

    frameWords = {32'h6261, 32'h6463, 32'h6665};
    sendFrame(32, 32'h5650, 32'h2D2A, 0);
    sendFrame(32, 32'h5650, 32'h2D2A, 3);
    sendFrame(32, 32'h5650, 32'h2D2A, 2);

    frameWords = {32'hFF};
    sendFrame(16, 32'hFF, 32'hFF, 0);
    sendFrame(16, 32'h00, 32'h00, 0);

    loadRandom(16, 10);
    s = correctSum(16);
    sendFrame(16, {24'd0, s[15:8]}, {24'd0, s[7:0]}, 1);

    for (int f = 0; f < 20; f++) begin
      for (int w = 16; w <= 32; w += 16) begin
        loadRandom(w, int'($urandom_range(12, 1)));
        s = correctSum(w);
        if ($urandom_range(1, 0) == 0) begin
          if (w == 16) sendFrame(w, {24'd0, s[15:8]}, {24'd0, s[7:0]}, int'($urandom_range(2, 0)));
          else         sendFrame(w, {16'd0, s[31:16]}, {16'd0, s[15:0]}, int'($urandom_range(2, 0)));
        end else begin
          sendFrame(w, $urandom() & ((w == 16) ? 32'hFF : 32'hFFFF),
                       $urandom() & ((w == 16) ? 32'hFF : 32'hFFFF), int'($urandom_range(2, 0)));
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    applyStimulus(16, 32'h61, 1'b0, 0);
    applyStimulus(16, 32'h62, 1'b0, 0);
    rst_ = 1'b0;
    #1;
    checkResetValues();
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("no_result_after_reset", rv16, 64'd0);
    end

    loadAbcde();
    sendFrame(16, 32'hC8, 32'hF0, 0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("drain_q16", q16.size(), 64'd0);
    checkOutput("drain_q32", q32.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fletcher_checksum_checker.md
# fletcher_checksum_checker

Streaming Fletcher checksum verifier: the receive-side counterpart of the FletcherChecksum generator. It consumes a frame of half-width data words followed by the two trailing checksum words the sender appended. It recomputes the checksum over the data words and reports pass/fail with the computed value and word count. It sits on the receive datapath after the link/FIFO, ahead of any consumer that must discard corrupt frames.

## Interface
- Width, 32, total checksum width; legal values 16, 32 and 64. H = Width/2 is the data word width.
- CountWidth, 16, width of the data-word counter.
- clk  in  1  block clock; all state is on its rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- in_valid  in  1  a word is presented on in_data.
- in_ready  out  1  the block can accept a word this cycle.
- in_data  in  H  data word or trailing checksum word.
- in_last  in  1  marks the final data word of the frame; only meaningful in DATA.
- res_valid  out  1  single-cycle pulse; result fields are valid.
- res_ok  out  1  the received checksum matches the computed one.
- res_sum  out  Width  computed checksum, {B, A}.
- res_count  out  CountWidth  number of data words in the frame, saturating.

## Operation
- A word transfers when in_valid && in_ready.
- Modulus M = 2^H − 1.
- Modular add: s = x + y (H+1 bits); r = s[H] ? s[H−1:0] + 1 : s[H−1:0]; then r == M maps to 0. A and B are therefore always in [0, M−1].
- Per data word: A' = A ⊕ in_data; B' = B ⊕ A', where ⊕ is the modular add. Both are computed in the same cycle, with A' feeding B'.
- A data word equal to M contributes the same as 0.
- Frame format: ≥1 data words (last one tagged in_last), then received B (high half), then received A (low half).
- Received halves are canonicalised before comparison: a value of M compares equal to 0.
- FSM states:
  - DATA: accumulate, count++. If in_last, go to CHK_B.
  - CHK_B: latch received B, go to CHK_A.
  - CHK_A: compare, go to RESULT.
  - RESULT: res_valid = 1, clear A, B and count, go to DATA.
- in_last is ignored in CHK_B and CHK_A.
- res_count saturates at 2^CountWidth − 1; the sums keep accumulating past saturation.

## Timing
- Reset values:
  - state = DATA; A = B = 0; count = 0.
  - in_ready = 1, res_valid = 0, res_ok = 0, res_sum = 0, res_count = 0.
- in_ready = 1 in DATA, CHK_B and CHK_A; 0 in RESULT (exactly one cycle). Back-to-back frames therefore lose one cycle.
- Gaps with in_valid low are allowed in any state; state and sums hold.
- Latency: res_valid rises the cycle after the CHK_A word is accepted.
- res_ok, res_sum and res_count are registered and hold until the next res_valid.
- The first data word of the next frame can be accepted the cycle after RESULT.
- Reset asserted mid-frame: immediately returns to reset values. The partial frame produces no result.

## Structure
- Shared package fletcher_pkg holds:
  - the legal Width values and the H = Width/2 derivation;
  - the state encoding (DATA, CHK_B, CHK_A, RESULT).
- Sub-module fletcher_mod_add (parameter H) implements the end-around-carry add plus the M→0 canonicalisation. It is instantiated twice in the datapath (A, B) and reused by the generator.

## Test plan
- Width=16: data 61,62,63,64,65 (in_last on 65), then C8, F0 → res_valid one cycle later; res_ok=1, res_sum=C8F0, res_count=5.
- Width=16, same frame but trailing F0, C8 → res_ok=0, res_sum=C8F0.
- Width=32: words 6261,6463,6665 (last), then 5650, 2D2A → res_ok=1, res_sum=56502D2A, res_count=3.
- Canonicalisation:
  - Width=16, single word FF (last), trailing FF, FF → res_sum=0000, res_ok=1.
  - Same frame with trailing 00, 00 → res_ok=1.
- Backpressure and recovery:
  - Random in_valid gaps over the Width=32 frame → identical result.
  - in_ready=0 exactly in the RESULT cycle.
  - Second frame back-to-back is checked correctly.
- Reset mid-frame:
  - Drop rst_ after 2 data words → all outputs at reset values, no res_valid.
  - A following full Width=16 "abcde" frame yields res_ok=1, res_count=5.
